id_decode_stage: RTL and testbench

- Registered, parametrised instruction-decode stage with a valid/ready handshake, a 2-entry skid buffer, flush, and immediate extension.
- Sits between the IF/ID boundary and the register-read/execute logic.
- Splits each instruction into opcode, RB, RD and immediate fields, and extends the immediate to datapath width.
- Flags opcodes outside the implemented range and counts instructions retired downstream.

---
 rtl/id_pkg.sv | 31 +++
 rtl/id_field_extract.sv | 53 +++++
 rtl/id_decode_stage.sv | 156 +++++++++++++++
 tb/tb_id_decode_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared constants, entry layout and field-position helpers for the decode stage
package id_pkg;

    localparam int EXT_ZERO = 0;
    localparam int EXT_SIGN = 1;
    localparam int EXT_MASK = 2;

    localparam int DEF_PC_W   = 32;
    localparam int DEF_OPC_W  = 5;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_DATA_W = 32;

    // Entry layout at the default widths; parametrised instances declare the same shape locally.
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_OPC_W-1:0]  opcode;
        logic [DEF_REG_W-1:0]  rb;
        logic [DEF_REG_W-1:0]  rd;
        logic [DEF_DATA_W-1:0] imm;
        logic                  illegal;
    } id_entry_t;

    function automatic int rb_msb(input int instr_w, input int opc_w);
        return instr_w - opc_w - 1;
    endfunction

    function automatic int rd_msb(input int instr_w, input int opc_w, input int reg_w);
        return instr_w - opc_w - reg_w - 1;
    endfunction

endpackage

// File: rtl/id_field_extract.sv
// rtl/id_field_extract.sv - combinational field slice, immediate extension and illegal-opcode check
module id_field_extract
    import id_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W = 5,
    parameter int REG_W = 5,
    parameter int IMM_W = 16,
    parameter int DATA_W = 32,
    parameter int EXT_MODE = 1,
    parameter logic [2**OPC_W-1:0] ZEXT_MASK = '0,
    parameter int NUM_OPS = 24
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rb,
    output logic [REG_W-1:0]   rd,
    output logic [DATA_W-1:0]  imm,
    output logic               illegal
);

    localparam int RB_MSB = rb_msb(INSTR_W, OPC_W);
    localparam int RD_MSB = rd_msb(INSTR_W, OPC_W, REG_W);

    logic use_sign;
    logic unused_gap;

    assign opcode  = instr[INSTR_W-1 -: OPC_W];
    assign rb      = instr[RB_MSB -: REG_W];
    assign rd      = instr[RD_MSB -: REG_W];
    assign illegal = (int'(opcode) >= NUM_OPS);

    // Bits between RD and the immediate carry no meaning for this stage.
    assign unused_gap = ^instr;

    always_comb begin
        use_sign = 1'b0;
        case (EXT_MODE)
            EXT_SIGN: use_sign = 1'b1;
            EXT_MASK: use_sign = !ZEXT_MASK[opcode];
            default:  use_sign = 1'b0;
        endcase
    end

    always_comb begin
        imm = '0;
        imm[IMM_W-1:0] = instr[IMM_W-1:0];
        for (int i = IMM_W; i < DATA_W; i++) begin
            imm[i] = use_sign & instr[IMM_W-1];
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - registered decode stage with output register, one skid entry and flush
module id_decode_stage
    import id_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W = 5,
    parameter int REG_W = 5,
    parameter int IMM_W = 16,
    parameter int DATA_W = 32,
    parameter int PC_W = 32,
    parameter int EXT_MODE = 1,
    parameter logic [2**OPC_W-1:0] ZEXT_MASK = '0,
    parameter int NUM_OPS = 24,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_rb,
    output logic [REG_W-1:0]   out_rd,
    output logic [DATA_W-1:0]  out_imm,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rb;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state, state_n;
    entry_t dec, m_q, s_q;
    logic   in_xfer, out_xfer;
    logic   load_m_in, load_m_skid, load_s;

    id_field_extract #(
        .INSTR_W  (INSTR_W),
        .OPC_W    (OPC_W),
        .REG_W    (REG_W),
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .EXT_MODE (EXT_MODE),
        .ZEXT_MASK(ZEXT_MASK),
        .NUM_OPS  (NUM_OPS)
    ) u_extract (
        .instr  (in_instr),
        .opcode (dec.opcode),
        .rb     (dec.rb),
        .rd     (dec.rd),
        .imm    (dec.imm),
        .illegal(dec.illegal)
    );

    assign dec.pc = in_pc;

    // Ready depends only on the state register, never on out_ready.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (flush) begin
            state_n = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_m_in = 1'b1;
                        state_n   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_m_in = 1'b1;
                    end else if (out_xfer) begin
                        state_n = ST_EMPTY;
                    end else if (in_xfer) begin
                        load_s  = 1'b1;
                        state_n = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        load_m_skid = 1'b1;
                        state_n     = ST_ONE;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m_in) begin
                m_q <= dec;
            end else if (load_m_skid) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= dec;
            end
        end
    end

    // Retirement is counted even in a flush cycle: the downstream handshake already happened.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (out_xfer) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end

    assign out_pc      = m_q.pc;
    assign out_opcode  = m_q.opcode;
    assign out_rb      = m_q.rb;
    assign out_rd      = m_q.rd;
    assign out_imm     = m_q.imm;
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - directed table-driven bench for id_decode_stage
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_opc, a_rb, a_rd;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [31:0] b_pc, b_imm;
    logic [4:0]  b_opc, b_rb, b_rd;
    logic [15:0] b_cnt;

    logic        c_in_ready, c_out_valid, c_ill;
    logic [31:0] c_pc, c_imm;
    logic [4:0]  c_opc, c_rb, c_rd;
    logic [3:0]  c_cnt;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_pc), .out_opcode(a_opc), .out_rb(a_rb),
        .out_rd(a_rd), .out_imm(a_imm), .out_illegal(a_ill), .retired_cnt(a_cnt)
    );

    id_decode_stage #(.EXT_MODE(2), .ZEXT_MASK(32'h0000_0002)) dut_m2 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_pc), .out_opcode(b_opc), .out_rb(b_rb),
        .out_rd(b_rd), .out_imm(b_imm), .out_illegal(b_ill), .retired_cnt(b_cnt)
    );

    id_decode_stage #(.CNT_W(4)) dut_c4 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_pc(c_pc), .out_opcode(c_opc), .out_rb(c_rb),
        .out_rd(c_rd), .out_imm(c_imm), .out_illegal(c_ill), .retired_cnt(c_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  opc;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] imm_m2;
        logic        ill;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0886_8005, 32'h100, 5'd1,  5'd2,  5'd3,  32'hFFFF_8005, 32'h0000_8005, 1'b0};
        vecs[1] = '{32'h1086_8005, 32'h104, 5'd2,  5'd2,  5'd3,  32'hFFFF_8005, 32'hFFFF_8005, 1'b0};
        vecs[2] = '{32'hF800_0000, 32'h108, 5'd31, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h5FFF_7FFF, 32'h10C, 5'd11, 5'd31, 5'd31, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0};
        vecs[4] = '{32'hC000_FFFF, 32'h110, 5'd24, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{32'h0801_1234, 32'h114, 5'd1,  5'd0,  5'd0,  32'h0000_1234, 32'h0000_1234, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, a_in_ready}, 32'd1);
        chk("reset_cnt", {16'b0, a_cnt}, 32'd0);
        chk("reset_out_pc", a_pc, 32'd0);
        chk("reset_out_imm", a_imm, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_instr = vecs[k].instr; in_pc = vecs[k].pc;
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", k), {31'b0, a_out_valid}, 32'd1);
            chk($sformatf("v%0d_pc", k), a_pc, vecs[k].pc);
            chk($sformatf("v%0d_opc", k), {27'b0, a_opc}, {27'b0, vecs[k].opc});
            chk($sformatf("v%0d_rb", k), {27'b0, a_rb}, {27'b0, vecs[k].rb});
            chk($sformatf("v%0d_rd", k), {27'b0, a_rd}, {27'b0, vecs[k].rd});
            chk($sformatf("v%0d_imm", k), a_imm, vecs[k].imm);
            chk($sformatf("v%0d_imm_m2", k), b_imm, vecs[k].imm_m2);
            chk($sformatf("v%0d_ill", k), {31'b0, a_ill}, {31'b0, vecs[k].ill});
            chk($sformatf("v%0d_cnt", k), {16'b0, a_cnt}, k);
        end
        step();
        chk("table_drain_valid", {31'b0, a_out_valid}, 32'd0);
        chk("table_drain_cnt", {16'b0, a_cnt}, 32'd6);

        // Back-pressure: two accepted, third held, then drained in order without bubbles.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h0;
        step();
        in_pc = 32'h4;
        chk("bp_ready_one", {31'b0, a_in_ready}, 32'd1);
        chk("bp_pc0_first", a_pc, 32'h0);
        step();
        in_pc = 32'h8;
        chk("bp_ready_full", {31'b0, a_in_ready}, 32'd0);
        chk("bp_pc0_held", a_pc, 32'h0);
        step();
        chk("bp_still_full", {31'b0, a_in_ready}, 32'd0);
        chk("bp_hold_pc", a_pc, 32'h0);
        chk("bp_hold_imm", a_imm, 32'hFFFF_8005);
        out_ready = 1'b1;
        step();
        chk("bp_pc4", a_pc, 32'h4);
        chk("bp_pc4_valid", {31'b0, a_out_valid}, 32'd1);
        chk("bp_ready_back", {31'b0, a_in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_pc8", a_pc, 32'h8);
        chk("bp_pc8_valid", {31'b0, a_out_valid}, 32'd1);
        step();
        chk("bp_empty", {31'b0, a_out_valid}, 32'd0);
        chk("bp_cnt", {16'b0, a_cnt}, 32'd9);

        // Flush from FULL with a concurrent input offer.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h200;
        step();
        in_pc = 32'h204;
        step();
        chk("fl_full", {31'b0, a_in_ready}, 32'd0);
        flush = 1'b1; in_pc = 32'h208;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {31'b0, a_out_valid}, 32'd0);
        chk("fl_ready", {31'b0, a_in_ready}, 32'd1);
        chk("fl_cnt", {16'b0, a_cnt}, 32'd9);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("fl_gone%0d", i), {31'b0, a_out_valid}, 32'd0);
        end
        chk("fl_cnt_after", {16'b0, a_cnt}, 32'd9);

        // Counter wrap on the CNT_W=4 instance.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        chk("wr_cnt0", {28'b0, c_cnt}, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_pc = 32'h1000 + 32'(4 * i);
            step();
            if (i == 15) chk("wr_cnt15", {28'b0, c_cnt}, 32'd15);
            if (i == 16) chk("wr_cnt_wrap", {28'b0, c_cnt}, 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("wr_cnt1", {28'b0, c_cnt}, 32'd1);
        chk("wr_cnt17", {16'b0, a_cnt}, 32'd17);

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1; in_pc = 32'h3000;
        step();
        step();
        chk("ar_pre_valid", {31'b0, a_out_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, a_out_valid}, 32'd0);
        chk("ar_cnt", {16'b0, a_cnt}, 32'd0);
        chk("ar_cnt_c4", {28'b0, c_cnt}, 32'd0);
        chk("ar_pc", a_pc, 32'd0);
        chk("ar_ready", {31'b0, a_in_ready}, 32'd1);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("ar_post_valid", {31'b0, a_out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
